fenpin_meter: RTL and testbench
===============================

FENPIN_METER -- requirements
Module: fenpin_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the period counter and of half_period.
REQ-002 SHALL have parameter LOCK_CNT, default 4: consecutive equal measurements needed to assert locked.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port clk_in  input  1  divided clock under test, asynchronous to clk.
REQ-007 SHALL have port half_period  output  WIDTH  last measured clk-cycle count between consecutive clk_in edges.
REQ-008 SHALL have port meas_valid  output  1  one-cycle pulse when half_period updates.
REQ-009 SHALL have port locked  output  1  high while measurements are stable.
REQ-010 SHALL have port err  output  1  one-cycle pulse when a measurement differs while locked.
REQ-011 SHALL have port timeout  output  1  one-cycle pulse when the counter saturates with no edge.

Function
REQ-012 SHALL pass clk_in through a 2-flop synchronizer (s1, s2), then a third flop s3; edge = s2 XOR s3 (both polarities).
REQ-013 SHALL run counter cnt: on edge load 1, else increment, saturating at MAX = 2^WIDTH-1.
REQ-014 SHALL, for clk_in toggling every N clk cycles (1 <= N <= MAX), measure cnt == N at each edge.
REQ-015 SHALL implement states IDLE, MEASURE, LOCKED.
REQ-016 IDLE: first edge -> MEASURE; no measurement taken; match count cleared.
REQ-017 MEASURE/LOCKED on edge: SHALL register half_period <= cnt and pulse meas_valid the next cycle.
REQ-018 SHALL increment the match count when cnt equals the previous measurement, else reset it to 1.
REQ-019 MEASURE -> LOCKED when the match count reaches LOCK_CNT; locked = 1 exactly while in LOCKED.
REQ-020 In LOCKED, an unequal measurement SHALL pulse err, go to MEASURE with match count 1, and still update half_period.
REQ-021 SHALL, when cnt == MAX with no edge in MEASURE/LOCKED, pulse timeout, go to IDLE, and clear locked and match count; half_period is held.
REQ-022 Edge coincident with cnt == MAX SHALL be treated as a valid measurement of MAX; no timeout.
REQ-023 In IDLE, cnt SHALL saturate silently with no timeout pulse.
REQ-024 Edge-to-meas_valid latency SHALL be fixed: clk_in transition -> meas_valid within 4 clk cycles (2 sync + edge + register).

Reset
REQ-025 rst SHALL asynchronously force state IDLE, s1/s2/s3 = 0, cnt = 0, match count = 0, half_period = 0, and meas_valid/locked/err/timeout = 0.
REQ-026 Reset mid-measurement SHALL discard all history; the first edge after release is treated as an IDLE edge.

Structure
REQ-027 Package fenpin_pkg SHALL hold the state enum (IDLE, MEASURE, LOCKED) and the default WIDTH/LOCK_CNT constants.
REQ-028 SHALL instantiate one sub-module, sync_edge (2-flop synchronizer plus edge detect, output edge pulse).
REQ-029 Counter, FSM, and compare logic SHALL reside in fenpin_meter.

Verification
REQ-030 Drive clk_in from the existing even divider with N=10 -> meas_valid every 10 cycles, half_period = 10, locked after 4 equal measurements.
REQ-031 N=1 (clk_in toggles every clk) -> half_period = 1, locked after 4 measurements.
REQ-032 While locked at N=10, switch to N=6 -> one err pulse, locked drops, half_period = 6, relock after 4 measurements.
REQ-033 WIDTH=8, stop clk_in while locked -> timeout pulse when cnt reaches 255, state IDLE, locked = 0, half_period holds 10.
REQ-034 Assert rst mid-period while locked -> all outputs 0 immediately; after release, the first edge produces no meas_valid.
REQ-035 WIDTH=8, clk_in toggling every 255 cycles -> half_period = 255, no timeout, lock achieved.

Source files
------------

// File: rtl/fenpin_pkg.sv
// Shared types and default sizing for the fenpin half-period meter.
package fenpin_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int LOCK_CNT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/fenpin_meter_sync_edge.sv
// Brings the asynchronous clk_in into the clk domain and flags every
// transition, rising or falling, as a single-cycle edge_pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic edge_pulse
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_pulse = s2_q ^ s3_q;

endmodule

// File: rtl/fenpin_meter.sv
// Measures clk cycles between clk_in transitions and tracks whether
// successive measurements agree.
//
// state   | meaning
// IDLE    | no reference edge yet; counter saturates silently
// MEASURE | measuring, fewer than LOCK_CNT consecutive equal results
// LOCKED  | LOCK_CNT or more consecutive equal results
module fenpin_meter
  import fenpin_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [WIDTH-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_CNT);

  logic edge_pulse;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hp_q, hp_d;
  logic [MW-1:0]    match_q, match_d;
  logic [MW-1:0]    match_inc;
  logic             mv_q, mv_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic             same;

  sync_edge u_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .d_in      (clk_in),
    .edge_pulse(edge_pulse)
  );

  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    match_d   = match_q;
    mv_d      = 1'b0;
    err_d     = 1'b0;
    to_d      = 1'b0;
    same      = (cnt_q == hp_q);
    match_inc = (match_q >= LOCK_M) ? LOCK_M : match_q + 1'b1;

    if (edge_pulse) begin
      cnt_d = WIDTH'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    // An edge always wins over saturation, so a period of exactly MAX is a measurement.
    case (state_q)
      IDLE: begin
        if (edge_pulse) begin
          state_d = MEASURE;
          match_d = '0;
        end
      end
      MEASURE: begin
        if (edge_pulse) begin
          hp_d    = cnt_q;
          mv_d    = 1'b1;
          match_d = same ? match_inc : MW'(1);
          if (match_d >= LOCK_M) state_d = LOCKED;
        end else if (cnt_q == CNT_MAX) begin
          to_d    = 1'b1;
          state_d = IDLE;
          match_d = '0;
        end
      end
      LOCKED: begin
        if (edge_pulse) begin
          hp_d = cnt_q;
          mv_d = 1'b1;
          if (same) begin
            match_d = match_inc;
          end else begin
            err_d   = 1'b1;
            state_d = MEASURE;
            match_d = MW'(1);
          end
        end else if (cnt_q == CNT_MAX) begin
          to_d    = 1'b1;
          state_d = IDLE;
          match_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        match_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hp_q    <= '0;
      match_q <= '0;
      mv_q    <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      match_q <= match_d;
      mv_q    <= mv_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign half_period = hp_q;
  assign meas_valid  = mv_q;
  assign locked      = (state_q == LOCKED);
  assign err         = err_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_fenpin_meter.sv
// Self-checking bench for fenpin_meter: table-driven segments, corner
// sequences and a random phase, all checked cycle by cycle against a gap model.
module tb_fenpin_meter;

  localparam int W     = 8;
  localparam int MAXC  = 255;
  localparam int LOCKN = 4;
  localparam int LAT   = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         clk_in;
  logic [W-1:0] half_period;
  logic         meas_valid, locked, err, timeout;

  fenpin_meter #(.WIDTH(W), .LOCK_CNT(LOCKN)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_in     (clk_in),
    .half_period(half_period),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;
  bit   trans_ring [8];
  logic prev_lvl;

  // Reference model: works on gaps between clk_in transitions.
  bit m_active, m_locked;
  int m_match, m_hp, m_last;
  int err_seen, mv_seen, to_seen;

  typedef struct {
    int n;
    int toggles;
    int exp_hp;
    int exp_locked;
    int exp_err;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_active = 0; m_locked = 0; m_match = 0; m_hp = 0; m_last = 0;
    for (int i = 0; i < 8; i++) trans_ring[i] = 0;
  endtask

  // Outputs seen after posedge cyc reflect a clk_in transition driven LAT cycles earlier.
  task automatic model_step(output logic [11:0] e);
    int t;
    int gap;
    bit mv, er, to;
    t = cyc - LAT;
    mv = 0; er = 0; to = 0;
    if (t >= 0 && trans_ring[t % 8]) begin
      if (!m_active) begin
        m_active = 1;
        m_match  = 0;
      end else begin
        gap = t - m_last;
        mv  = 1;
        if (gap == m_hp) m_match = (m_match < LOCKN) ? m_match + 1 : LOCKN;
        else m_match = 1;
        if (m_locked && gap != m_hp) begin
          er = 1;
          m_locked = 0;
        end else if (m_match >= LOCKN) begin
          m_locked = 1;
        end
        m_hp = gap;
      end
      m_last = t;
    end else if (m_active && (t - m_last) == MAXC) begin
      to = 1; m_active = 0; m_locked = 0; m_match = 0;
    end
    e = {8'(m_hp), mv, m_locked, er, to};
  endtask

  task automatic tick(input logic lvl);
    logic [11:0] e, a;
    @(posedge clk);
    #1;
    cyc++;
    model_step(e);
    a = {half_period, meas_valid, locked, err, timeout};
    check($sformatf("outputs@cyc%0d", cyc), int'(a), int'(e));
    err_seen += int'(err);
    mv_seen  += int'(meas_valid);
    to_seen  += int'(timeout);
    clk_in = lvl;
    trans_ring[cyc % 8] = (lvl != prev_lvl);
    prev_lvl = lvl;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick(prev_lvl);
  endtask

  task automatic toggle_after(input int n);
    hold(n - 1);
    tick(~prev_lvl);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{10,  8, 10,  1, 0};
    tbl[1] = '{6,   8, 6,   1, 1};
    tbl[2] = '{1,   8, 1,   1, 1};
    tbl[3] = '{255, 6, 255, 1, 1};
    tbl[4] = '{10,  8, 10,  1, 1};
    tbl[5] = '{3,   3, 3,   0, 1};
    tbl[6] = '{10,  8, 10,  1, 0};

    rst = 1'b0; clk_in = 1'b0; prev_lvl = 1'b0;
    err_seen = 0; mv_seen = 0; to_seen = 0;
    model_reset();
    #1 rst = 1'b1;
    #1 check("reset_outputs", int'({half_period, meas_valid, locked, err, timeout}), 0);
    hold(2);
    rst = 1'b0;

    // Table segments; the 3 trailing holds are credited to the next segment's first gap.
    for (int i = 0; i < 7; i++) begin
      err_seen = 0;
      for (int k = 0; k < tbl[i].toggles; k++)
        toggle_after((k == 0 && tbl[i].n > LAT) ? tbl[i].n - LAT : tbl[i].n);
      hold(LAT);
      check($sformatf("seg%0d_half_period", i), int'(half_period), tbl[i].exp_hp);
      check($sformatf("seg%0d_locked", i), int'(locked), tbl[i].exp_locked);
      check($sformatf("seg%0d_err_pulses", i), err_seen, tbl[i].exp_err);
    end

    // Stop clk_in while locked at 10: timeout 258 cycles after the last transition.
    n = 0;
    to_seen = 0;
    while (!timeout && n < 400) begin
      hold(1);
      n++;
    end
    check("timeout_latency", n, MAXC - LAT + LAT);
    check("timeout_locked", int'(locked), 0);
    check("timeout_half_period", int'(half_period), 10);
    to_seen = 0;
    hold(300);
    check("idle_no_timeout", to_seen, 0);

    // Relock at 10, then reset in the middle of a period.
    for (int k = 0; k < 8; k++) toggle_after(10);
    hold(5);
    check("pre_rst_locked", int'(locked), 1);
    @(posedge clk);
    cyc++;
    #3;
    rst = 1'b1;
    clk_in = 1'b0;
    prev_lvl = 1'b0;
    model_reset();
    #1 check("rst_async_outputs", int'({half_period, meas_valid, locked, err, timeout}), 0);
    hold(2);
    rst = 1'b0;
    mv_seen = 0;
    toggle_after(10);
    hold(6);
    check("first_edge_after_rst_mv", mv_seen, 0);
    check("first_edge_after_rst_hp", int'(half_period), 0);

    // Random gaps, repeated to allow locking, with some straddling the saturation point.
    for (int s = 0; s < 40; s++) begin
      int g, r, sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        g = $urandom_range(1, 12);
        r = $urandom_range(1, 6);
      end else if (sel < 8) begin
        g = $urandom_range(20, 60);
        r = $urandom_range(1, 5);
      end else begin
        g = $urandom_range(250, 262);
        r = $urandom_range(1, 2);
      end
      for (int k = 0; k < r; k++) toggle_after(g);
    end
    hold(LAT + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
